// File: rtl/channel_data_pkg.sv
// Constants and FSM state type shared by the channel-grouped DRAM read and write paths.
package channel_data_pkg;

    localparam int unsigned DATA_WIDTH       = 16;
    localparam int unsigned WORD_WIDTH       = 256;
    localparam int unsigned SAMPLES_PER_WORD = WORD_WIDTH / DATA_WIDTH;
    localparam logic [DATA_WIDTH-1:0] HEADER_WORD = 16'hDEAD;

    typedef enum logic [2:0] {
        StIdle,
        StHeader,
        StFrameId,
        StLoad,
        StShift
    } state_e;

endpackage

// File: rtl/word_to_sample_shifter.sv
// Holds one DRAM word and presents its samples in order, lowest sample first.
module word_to_sample_shifter
    import channel_data_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [WORD_WIDTH-1:0] word,
    input  logic                  advance,
    output logic [DATA_WIDTH-1:0] sample,
    output logic                  last
);

    localparam int unsigned IDX_W = $clog2(SAMPLES_PER_WORD);

    logic [WORD_WIDTH-1:0] hold_q;
    logic [IDX_W-1:0]      sample_idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q       <= '0;
            sample_idx_q <= '0;
        end else if (load) begin
            hold_q       <= word;
            sample_idx_q <= '0;
        end else if (advance) begin
            sample_idx_q <= sample_idx_q + IDX_W'(1);
        end
    end

    assign sample = hold_q[sample_idx_q * DATA_WIDTH +: DATA_WIDTH];
    assign last   = (sample_idx_q == IDX_W'(SAMPLES_PER_WORD - 1));

endmodule

// File: rtl/channel_data_readout_serializer.sv
// Serializes channel-grouped DRAM words into a framed 16-bit stream: header, frame ID, samples.
module channel_data_readout_serializer
    import channel_data_pkg::*;
#(
    parameter int unsigned WORDS_PER_FRAME = 124
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  DRAM_data_ready,
    input  logic [WORD_WIDTH-1:0] DRAM_rd_data,
    output logic                  DRAM_rd_request,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  frame_active,
    output logic [DATA_WIDTH-1:0] frame_id
);

    localparam int unsigned CNT_W = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_FRAME - 1);

    state_e                state_q;
    logic [DATA_WIDTH-1:0] ctrl_data_q;
    logic [DATA_WIDTH-1:0] frame_id_q;
    logic                  out_valid_q;
    logic                  frame_active_q;
    logic [CNT_W-1:0]      word_cnt_q;

    logic                  xfer;
    logic                  advance;
    logic                  last_sample;
    logic [DATA_WIDTH-1:0] sample;

    assign xfer            = out_valid_q && out_ready;
    assign DRAM_rd_request = (state_q == StLoad) && DRAM_data_ready;
    assign advance         = (state_q == StShift) && xfer;

    word_to_sample_shifter u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (DRAM_rd_request),
        .word    (DRAM_rd_data),
        .advance (advance),
        .sample  (sample),
        .last    (last_sample)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            ctrl_data_q    <= '0;
            frame_id_q     <= '0;
            out_valid_q    <= 1'b0;
            frame_active_q <= 1'b0;
            word_cnt_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    out_valid_q <= 1'b0;
                    if (enable && DRAM_data_ready) begin
                        ctrl_data_q    <= HEADER_WORD;
                        out_valid_q    <= 1'b1;
                        frame_active_q <= 1'b1;
                        state_q        <= StHeader;
                    end
                end
                StHeader: begin
                    if (xfer) begin
                        ctrl_data_q <= frame_id_q;
                        state_q     <= StFrameId;
                    end
                end
                StFrameId: begin
                    // The ID on the wire is the pre-increment value.
                    if (xfer) begin
                        frame_id_q  <= frame_id_q + DATA_WIDTH'(1);
                        out_valid_q <= 1'b0;
                        word_cnt_q  <= '0;
                        state_q     <= StLoad;
                    end
                end
                StLoad: begin
                    if (DRAM_data_ready) begin
                        out_valid_q <= 1'b1;
                        state_q     <= StShift;
                    end
                end
                StShift: begin
                    if (xfer && last_sample) begin
                        out_valid_q <= 1'b0;
                        if (word_cnt_q == LAST_WORD) begin
                            frame_active_q <= 1'b0;
                            state_q        <= StIdle;
                        end else begin
                            word_cnt_q <= word_cnt_q + CNT_W'(1);
                            state_q    <= StLoad;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Both mux inputs are registers and the select is registered state.
    assign out_data     = (state_q == StShift) ? sample : ctrl_data_q;
    assign out_valid    = out_valid_q;
    assign frame_active = frame_active_q;
    assign frame_id     = frame_id_q;

endmodule

// File: tb/tb_channel_data_readout_serializer.sv
// Directed bench for the readout serializer with a two-word frame.
module tb_channel_data_readout_serializer;

    localparam int FRAME_LEN = 34;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic         DRAM_data_ready;
    logic [255:0] DRAM_rd_data;
    logic         DRAM_rd_request;
    logic [15:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         frame_active;
    logic [15:0]  frame_id;

    int          check_cnt = 0;
    int          pass_cnt  = 0;
    logic [15:0] stream[$];
    int          rd_count  = 0;
    int          word_idx  = 0;
    logic        mon_consume;

    always #5 clk = ~clk;

    channel_data_readout_serializer #(
        .WORDS_PER_FRAME (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .DRAM_data_ready (DRAM_data_ready),
        .DRAM_rd_data    (DRAM_rd_data),
        .DRAM_rd_request (DRAM_rd_request),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .frame_active    (frame_active),
        .frame_id        (frame_id)
    );

    function automatic logic [255:0] make_word(input int n);
        logic [255:0] w;
        for (int k = 0; k < 16; k++) w[16*k +: 16] = 16'((n + 1) * 256 + k);
        return w;
    endfunction

    function automatic logic [15:0] exp_word(input int i, input logic [15:0] id);
        if (i == 0) return 16'hDEAD;
        if (i == 1) return id;
        return 16'((((i - 2) / 16) + 1) * 256 + ((i - 2) % 16));
    endfunction

    // Mismatches of stream[base +: FRAME_LEN] against a full frame, plus a length error.
    function automatic int frame_errors(input logic [15:0] id, input int base);
        int e = 0;
        if (stream.size() != base + FRAME_LEN) e++;
        for (int i = 0; i < FRAME_LEN; i++) begin
            if (base + i >= stream.size()) e++;
            else if (stream[base + i] !== exp_word(i, id)) e++;
        end
        return e;
    endfunction

    // DRAM model (show-ahead) and output capture.
    initial begin
        forever begin
            @(negedge clk);
            mon_consume = DRAM_rd_request && DRAM_data_ready;
            if (out_valid && out_ready) stream.push_back(out_data);
            @(posedge clk);
            #1;
            if (mon_consume && rst_n) begin
                rd_count++;
                word_idx++;
                DRAM_rd_data = make_word(word_idx % 2);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    task automatic wait_stream(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (stream.size() >= n) break;
        end
    endtask

    task automatic wait_consumed(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (rd_count >= n) break;
        end
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        enable          = 1'b0;
        DRAM_data_ready = 1'b1;
        out_ready       = 1'b1;
        DRAM_rd_data    = make_word(0);
        repeat (3) @(negedge clk);
        check_cnt++;
        if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b required 0", out_valid);
        else pass_cnt++;
        check_cnt++;
        if (out_data !== 16'h0000) $display("FAIL rst_out_data: got %h required 0000", out_data);
        else pass_cnt++;
        check_cnt++;
        if (frame_active !== 1'b0) $display("FAIL rst_frame_active: got %b required 0", frame_active);
        else pass_cnt++;
        check_cnt++;
        if (frame_id !== 16'h0000) $display("FAIL rst_frame_id: got %h required 0000", frame_id);
        else pass_cnt++;
        check_cnt++;
        if (DRAM_rd_request !== 1'b0) $display("FAIL rst_rd_request: got %b required 0", DRAM_rd_request);
        else pass_cnt++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic_frame();
        int e;
        stream.delete();
        rd_count = 0;
        @(posedge clk);
        #1 enable = 1'b1;
        @(negedge clk);
        check_cnt++;
        if (out_valid !== 1'b0) $display("FAIL hdr_not_early: got valid %b required 0", out_valid);
        else pass_cnt++;
        @(negedge clk);
        check_cnt++;
        if (out_valid !== 1'b1 || out_data !== 16'hDEAD || frame_active !== 1'b1)
            $display("FAIL hdr_latency: got valid %b data %h active %b required 1 DEAD 1",
                     out_valid, out_data, frame_active);
        else pass_cnt++;
        @(posedge clk);
        #1 enable = 1'b0;
        wait_stream(FRAME_LEN, 200);
        check_cnt++;
        if (frame_active !== 1'b1) $display("FAIL active_at_last: got %b required 1", frame_active);
        else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        e = frame_errors(16'h0000, 0);
        check_cnt++;
        if (e !== 0) $display("FAIL basic_stream: got %0d mismatches required 0", e);
        else pass_cnt++;
        check_cnt++;
        if (rd_count !== 2) $display("FAIL basic_rd_pulses: got %0d required 2", rd_count);
        else pass_cnt++;
        check_cnt++;
        if (frame_active !== 1'b0) $display("FAIL active_after_last: got %b required 0", frame_active);
        else pass_cnt++;
        check_cnt++;
        if (frame_id !== 16'h0001) $display("FAIL basic_next_id: got %h required 0001", frame_id);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int          e;
        int          unstable = 0;
        int          stalls   = 0;
        logic        prev_stall = 1'b0;
        logic [15:0] prev_data  = '0;
        stream.delete();
        @(posedge clk);
        #1 enable = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            if (frame_active) enable = 1'b0;
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data)) unstable++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (prev_stall) stalls++;
            #1;
            if (stream.size() >= FRAME_LEN && !frame_active) break;
        end
        out_ready = 1'b1;
        enable    = 1'b0;
        repeat (2) @(posedge clk);
        e = frame_errors(16'h0001, 0);
        check_cnt++;
        if (e !== 0) $display("FAIL bp_stream: got %0d mismatches required 0", e);
        else pass_cnt++;
        check_cnt++;
        if (unstable !== 0) $display("FAIL bp_stable: got %0d unstable cycles of %0d stalls required 0",
                                     unstable, stalls);
        else pass_cnt++;
    endtask

    task automatic test_dram_stall();
        int e;
        int viol = 0;
        int held;
        stream.delete();
        rd_count = 0;
        @(posedge clk);
        #1 enable = 1'b1;
        wait_consumed(1, 100);
        @(posedge clk);
        #1;
        enable          = 1'b0;
        DRAM_data_ready = 1'b0;
        wait_stream(18, 100);
        @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (DRAM_rd_request !== 1'b0 || out_valid !== 1'b0) viol++;
        end
        held = stream.size();
        check_cnt++;
        if (viol !== 0) $display("FAIL stall_quiet: got %0d active cycles required 0", viol);
        else pass_cnt++;
        check_cnt++;
        if (held !== 18) $display("FAIL stall_count: got %0d samples required 18", held);
        else pass_cnt++;
        @(posedge clk);
        #1 DRAM_data_ready = 1'b1;
        wait_stream(FRAME_LEN, 200);
        repeat (3) @(posedge clk);
        e = frame_errors(16'h0002, 0);
        check_cnt++;
        if (e !== 0) $display("FAIL stall_stream: got %0d mismatches required 0", e);
        else pass_cnt++;
    endtask

    task automatic test_frame_id_wrap();
        int e;
        stream.delete();
        @(posedge clk);
        force dut.frame_id_q = 16'hFFFF;
        @(posedge clk);
        #1 release dut.frame_id_q;
        @(negedge clk);
        check_cnt++;
        if (frame_id !== 16'hFFFF) $display("FAIL wrap_preload: got %h required FFFF", frame_id);
        else pass_cnt++;
        @(posedge clk);
        #1 enable = 1'b1;
        wait_stream(1, 20);
        @(posedge clk);
        #1 enable = 1'b0;
        wait_stream(FRAME_LEN, 200);
        repeat (3) @(posedge clk);
        e = frame_errors(16'hFFFF, 0);
        check_cnt++;
        if (e !== 0) $display("FAIL wrap_stream_ffff: got %0d mismatches required 0", e);
        else pass_cnt++;
        check_cnt++;
        if (frame_id !== 16'h0000) $display("FAIL wrap_id: got %h required 0000", frame_id);
        else pass_cnt++;
        stream.delete();
        @(posedge clk);
        #1 enable = 1'b1;
        wait_stream(1, 20);
        @(posedge clk);
        #1 enable = 1'b0;
        wait_stream(FRAME_LEN, 200);
        repeat (3) @(posedge clk);
        e = frame_errors(16'h0000, 0);
        check_cnt++;
        if (e !== 0) $display("FAIL wrap_stream_0000: got %0d mismatches required 0", e);
        else pass_cnt++;
    endtask

    task automatic test_enable_deassert();
        int e;
        int busy = 0;
        stream.delete();
        rd_count = 0;
        @(posedge clk);
        #1 enable = 1'b1;
        wait_consumed(1, 100);
        @(posedge clk);
        #1 enable = 1'b0;
        wait_stream(FRAME_LEN, 200);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || frame_active !== 1'b0) busy++;
        end
        e = frame_errors(16'h0001, 0);
        check_cnt++;
        if (e !== 0) $display("FAIL en_full_frame: got %0d mismatches required 0", e);
        else pass_cnt++;
        check_cnt++;
        if (busy !== 0) $display("FAIL en_idle_hold: got %0d busy cycles required 0", busy);
        else pass_cnt++;
        rd_count = 0;
        @(posedge clk);
        #1 enable = 1'b1;
        wait_stream(FRAME_LEN + 1, 20);
        check_cnt++;
        if (stream.size() < FRAME_LEN + 1 || stream[FRAME_LEN] !== 16'hDEAD)
            $display("FAIL en_restart: got %0d words required DEAD at index %0d",
                     stream.size(), FRAME_LEN);
        else pass_cnt++;
        @(posedge clk);
        #1 enable = 1'b0;
    endtask

    task automatic test_async_reset();
        int e;
        wait_consumed(1, 100);
        repeat (3) @(posedge clk);
        #1;
        check_cnt++;
        if (out_valid !== 1'b1) $display("FAIL ar_in_shift: got valid %b required 1", out_valid);
        else pass_cnt++;
        #1 rst_n = 1'b0;
        #1;
        check_cnt++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000)
            $display("FAIL ar_outputs: got valid %b data %h required 0 0000", out_valid, out_data);
        else pass_cnt++;
        check_cnt++;
        if (frame_active !== 1'b0 || frame_id !== 16'h0000)
            $display("FAIL ar_frame: got active %b id %h required 0 0000", frame_active, frame_id);
        else pass_cnt++;
        check_cnt++;
        if (DRAM_rd_request !== 1'b0) $display("FAIL ar_rd_request: got %b required 0", DRAM_rd_request);
        else pass_cnt++;
        word_idx     = 0;
        DRAM_rd_data = make_word(0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        stream.delete();
        @(posedge clk);
        #1 enable = 1'b1;
        wait_stream(1, 20);
        @(posedge clk);
        #1 enable = 1'b0;
        wait_stream(FRAME_LEN, 200);
        repeat (3) @(posedge clk);
        e = frame_errors(16'h0000, 0);
        check_cnt++;
        if (e !== 0) $display("FAIL ar_new_frame: got %0d mismatches required 0", e);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_dram_stall();
        test_frame_id_wrap();
        test_enable_deassert();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
